instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front-end stage that feeds the control unit its instruction bytes.
- Owns the program counter and issues byte reads to instruction memory over a req/ack handshake, which tolerates wait states.
- Buffers fetched bytes in a small prefetch FIFO and presents them downstream over a valid/ready interface.
- Supports redirect (jump/branch target load with flush) and halt.

Parameters:
- ADDR_W, 8, program counter and memory address width.
- DATA_W, 8, instruction byte width (opcode in [7:3], operand in [2:0]).
- DEPTH, 2, prefetch FIFO entries; power of two, ≥1.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset asserted, sampled on rising clk).
- memAddr  out  ADDR_W  fetch address; held stable while memReq=1 and no ack.
- memReq  out  1  read request to instruction memory.
- memAck  in  1  memory completion; memData valid in the same cycle.
- memData  in  DATA_W  fetched instruction byte.
- instr  out  DATA_W  head-of-FIFO instruction byte.
- instrPc  out  ADDR_W  address that instr was fetched from.
- instrValid  out  1  FIFO non-empty.
- instrReady  in  1  control unit consumes the head this cycle.
- redirect  in  1  load new PC and flush, single-cycle pulse.
- redirectPc  in  ADDR_W  redirect target.
- halt  in  1  level; suppresses new requests while high.

Behaviour:
- Reset (rst=0 at a rising edge):
  - pc=RESET_PC, memReq=0, memAddr=RESET_PC.
  - FIFO empty, so instrValid=0; instr=0, instrPc=0.
  - discard flag=0, FSM=IDLE.
  - Reset dominates every other input.
  - Reset mid-request abandons the request; memory must tolerate a dropped request.
- FSM, 2 states:
  - IDLE:
    - Issue condition: halt=0, redirect=0, and (count − pop + 0) < DEPTH, where pop = instrValid & instrReady.
    - When the condition holds, memReq=1 and memAddr=pc are asserted combinationally in the same cycle, and the request is live.
    - If memAck=1 in that cycle (zero-wait memory), the transaction completes at that edge and the FSM stays in IDLE.
    - Otherwise the FSM goes to BUSY.
  - BUSY:
    - memReq=1, memAddr held.
    - On memAck, the FSM returns to IDLE.
    - At most one outstanding request at any time.
- Completion, at the edge where memReq&memAck:
  - If discard=0: push {memData, memAddr} into the FIFO and set pc=memAddr+1, mod 2^ADDR_W (0xFF wraps to 0x00).
  - If discard=1: drop the data, leave pc unchanged, clear discard.
- Output latency:
  - A byte acked at edge T is visible (instrValid=1) in cycle T+1.
  - Sustained throughput is 1 byte/cycle with zero-wait memory and instrReady=1.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full.
  - Push is never attempted when full, which the issue rule guarantees.
  - Pop when empty is ignored.
  - instr and instrPc are driven from the head entry registers, not combinationally from memData.
- Redirect (redirect=1 at an edge):
  - FIFO flushed; a concurrent pop is irrelevant.
  - pc=redirectPc.
  - If a request is live and not acked this cycle, set discard=1; memReq stays high until the ack.
  - If a request is acked in the same cycle, its data is dropped.
  - No new request is issued in the redirect cycle; fetch from redirectPc starts the next cycle.
  - redirect overrides halt for the PC load and flush.
- Halt:
  - Blocks new issue only.
  - An outstanding request completes normally, and the FIFO continues to drain.
  - Deasserting halt resumes fetch from pc the next cycle.
- Assertion: memAddr must not change while memReq=1 and memAck=0.

Decomposition:
- Shared package cpu_pkg holds ADDR_W/DATA_W defaults, the RESET_PC constant, and the fetch FSM state encoding (IDLE=0, BUSY=1).
- One sub-module, fetch_fifo: parameterised synchronous FIFO with DEPTH entries of {DATA_W, ADDR_W}, a flush input, and push/pop/count/empty/full.
- The top level holds the PC, FSM, discard flag and issue logic.

Test Plan:
- Reset, then zero-wait memory (ack=req), memory[i]=i+0x10, instrReady=1:
  - memAddr sequence is 0,1,2,...
  - instr=0x10,0x11,... on consecutive cycles starting 1 cycle after the first ack.
  - instrPc matches.
- Hold instrReady=0 with zero-wait memory:
  - Exactly DEPTH=2 bytes are fetched (addr 0,1), then memReq=0.
  - Raising instrReady gives 0x10, 0x11, then fetching resumes at addr 2 with no byte lost or duplicated.
- Memory with 3 wait states:
  - memReq stays high and memAddr is stable for 4 cycles per byte.
  - One byte per 4 cycles reaches the output.
- Redirect to 0x40 while a request to addr 5 is in BUSY:
  - memReq is held until the ack, and that byte is discarded.
  - The FIFO is empty the next cycle.
  - The next memAddr is 0x40; the first instr out has instrPc=0x40.
- Start at redirectPc=0xFE, zero-wait memory:
  - Addresses 0xFE, 0xFF, 0x00, 0x01 are fetched in order (wrap).
- Halt during BUSY:
  - The outstanding byte is delivered and no further memReq is raised.
  - Release halt: the next request is at pc+1.
- Assert rst=0 mid-BUSY:
  - Next cycle memReq=0, instrValid=0, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default bus widths, reset PC and the
// fetch FSM state encoding.
package cpu_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 8;
    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fetchState_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel plus the
// valid/ready instruction stream towards the control unit.
interface instr_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
);

    logic [ADDR_W-1:0] memAddr;
    logic              memReq;
    logic              memAck;
    logic [DATA_W-1:0] memData;

    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instrPc;
    logic              instrValid;
    logic              instrReady;

    modport master (
        output memAddr, memReq,
        input  memAck, memData,
        output instr, instrPc, instrValid,
        input  instrReady
    );

    modport slave (
        input  memAddr, memReq,
        output memAck, memData,
        input  instr, instrPc, instrValid,
        output instrReady
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {byte, fetch address} entries; flush empties it in
// one cycle, and push/pop in the same cycle are both honoured even when full.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] headData,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign doPop    = pop && !empty;
    assign doPush   = push && (!full || doPop);
    assign headData = storage[rdPtr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // NOTE: storage is cleared on reset only because it is tiny and the head
    // outputs must read zero out of reset; deeper FIFOs should leave data unreset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (doPush) begin
            storage[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one outstanding byte read
// at a time, and streams fetched bytes through a prefetch FIFO.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = CPU_ADDR_W,
    parameter int              DATA_W   = CPU_DATA_W,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectPc,
    input  logic              halt,
    instr_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetchState_e        state;
    fetchState_e        stateNext;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  reqAddr;
    logic               discard;
    logic               issue;
    logic               pop;
    logic               done;
    logic               push;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               full;
    logic [DATA_W+ADDR_W-1:0] headEntry;

    assign pop  = bus.instrValid && bus.instrReady;
    assign done = bus.memReq && bus.memAck;
    // A completion in the redirect cycle belongs to the old stream and is dropped.
    assign push = done && !discard && !redirect;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        issue       = 1'b0;
        bus.memReq  = 1'b0;
        bus.memAddr = (state == BUSY) ? reqAddr : pc;
        if (rst) begin
            if (state == BUSY) begin
                bus.memReq = 1'b1;
            end else begin
                issue      = !halt && !redirect && ((int'(count) - int'(pop)) < DEPTH);
                bus.memReq = issue;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (issue && !bus.memAck) stateNext = BUSY;
            BUSY:    if (bus.memAck) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            reqAddr <= RESET_PC;
            discard <= 1'b0;
        end else begin
            state <= stateNext;
            if (issue) reqAddr <= pc;

            if (redirect)  pc <= redirectPc;
            else if (push) pc <= bus.memAddr + ADDR_W'(1);

            if (redirect && bus.memReq && !bus.memAck) discard <= 1'b1;
            else if (done)                              discard <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (push),
        .pop      (pop),
        .pushData ({bus.memData, bus.memAddr}),
        .headData (headEntry),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    assign bus.instr      = headEntry[ADDR_W +: DATA_W];
    assign bus.instrPc    = headEntry[ADDR_W-1:0];
    assign bus.instrValid = !empty;

    memAddrStable: assert property (@(posedge clk) disable iff (!rst)
        (bus.memReq && !bus.memAck) |=> $stable(bus.memAddr));

    noOverflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: wait-state memory model,
// instruction scoreboard, directed corner sequences and a redirect table.
module tb_instr_fetch_unit;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] pc;
    } expEntry_t;

    typedef struct {
        logic [7:0] target;
        int         waits;
        int         nBytes;
        logic [7:0] lastPc;
        logic [7:0] lastInstr;
    } vector_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       redirect;
    logic [7:0] redirectPc;
    logic       halt;

    int nCompared   = 0;
    int nMismatched = 0;

    int         waitCfg = 0;
    int         waitCnt = 0;
    bit         chkAddr = 1'b0;
    bit         strictAddr = 1'b0;
    logic [7:0] lastPc = '0;
    logic [7:0] lastInstr = '0;

    expEntry_t  expQ[$];
    logic [7:0] addrQ[$];
    vector_t    vectors[4];

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .halt       (halt),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memByte(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    // Memory model: data follows the address combinationally, ack after waitCfg wait states.
    assign bus.memData = memByte(bus.memAddr);
    assign bus.memAck  = bus.memReq && (waitCnt == waitCfg);

    always @(posedge clk) waitCnt <= (bus.memReq && !bus.memAck) ? waitCnt + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every consumed byte and, when enabled, every memory completion.
    always @(negedge clk) begin
        expEntry_t e;
        if (bus.instrValid && bus.instrReady) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL unexpected_instr: got 0x%0h at pc 0x%0h, expected no byte", bus.instr, bus.instrPc);
            end else begin
                e = expQ.pop_front();
                check("instr", bus.instr, e.instr);
                check("instrPc", bus.instrPc, e.pc);
                lastPc    = bus.instrPc;
                lastInstr = bus.instr;
            end
        end
        if (chkAddr && bus.memReq && bus.memAck) begin
            if (addrQ.size() > 0) begin
                check("memAddr_seq", bus.memAddr, addrQ.pop_front());
            end else if (strictAddr) begin
                nCompared++;
                nMismatched++;
                $display("FAIL extra_fetch: got fetch at 0x%0h, expected none", bus.memAddr);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [7:0] pc);
        expQ.push_back('{instr: memByte(pc), pc: pc});
    endtask

    task automatic startAt(input logic [7:0] target, input int waits, input logic rdy, input bit chk);
        bit idleSeen = 1'b0;
        halt = 1'b1;
        bus.instrReady = 1'b0;
        for (int i = 0; i < 50 && !idleSeen; i++) begin
            @(negedge clk);
            idleSeen = !bus.memReq;
        end
        check("idle_before_redirect", idleSeen, 1);
        cyc();
        redirect   = 1'b1;
        redirectPc = target;
        cyc();
        redirect       = 1'b0;
        waitCfg        = waits;
        halt           = 1'b0;
        bus.instrReady = rdy;
        chkAddr        = chk;
    endtask

    task automatic runUntilDrained(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        check(name, expQ.size(), 0);
        bus.instrReady = 1'b0;
        halt = 1'b1;
    endtask

    task automatic waitReqAt(input logic [7:0] a, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = bus.memReq && !bus.memAck && (bus.memAddr == a);
        end
        check(name, found, 1);
    endtask

    initial begin
        int reqSeen;

        vectors[0] = '{target: 8'hFE, waits: 0, nBytes: 4, lastPc: 8'h01, lastInstr: 8'h11};
        vectors[1] = '{target: 8'h00, waits: 0, nBytes: 3, lastPc: 8'h02, lastInstr: 8'h12};
        vectors[2] = '{target: 8'h30, waits: 1, nBytes: 3, lastPc: 8'h32, lastInstr: 8'h42};
        vectors[3] = '{target: 8'hFF, waits: 3, nBytes: 2, lastPc: 8'h00, lastInstr: 8'h10};

        rst = 1'b0;
        halt = 1'b0;
        redirect = 1'b0;
        redirectPc = '0;
        bus.instrReady = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_memReq", bus.memReq, 0);
        check("rst_memAddr", bus.memAddr, 8'h00);
        check("rst_instrValid", bus.instrValid, 0);
        check("rst_instr", bus.instr, 8'h00);
        check("rst_instrPc", bus.instrPc, 8'h00);

        // Zero-wait streaming: one byte per cycle from the cycle after the first ack
        for (int i = 0; i < 8; i++) pushExp(8'(i));
        for (int i = 0; i < 9; i++) addrQ.push_back(8'(i));
        chkAddr = 1'b1;
        strictAddr = 1'b1;
        cyc();
        rst = 1'b1;
        repeat (9) cyc();
        bus.instrReady = 1'b0;
        halt = 1'b1;
        chkAddr = 1'b0;
        check("stream_leftover", expQ.size(), 0);
        check("stream_addr_left", addrQ.size(), 0);

        // Backpressure: exactly DEPTH bytes prefetched, then resume without loss
        addrQ.delete();
        addrQ.push_back(8'h00);
        addrQ.push_back(8'h01);
        startAt(8'h00, 0, 1'b0, 1'b1);
        repeat (5) cyc();
        @(negedge clk);
        check("bp_memReq_idle", bus.memReq, 0);
        check("bp_valid", bus.instrValid, 1);
        check("bp_addr_left", addrQ.size(), 0);
        cyc();
        for (int i = 0; i < 4; i++) pushExp(8'(i));
        for (int i = 2; i < 6; i++) addrQ.push_back(8'(i));
        bus.instrReady = 1'b1;
        repeat (4) cyc();
        bus.instrReady = 1'b0;
        halt = 1'b1;
        chkAddr = 1'b0;
        strictAddr = 1'b0;
        check("bp_leftover", expQ.size(), 0);
        check("bp_addr_left2", addrQ.size(), 0);

        // Three wait states: request held and address stable for 4 cycles per byte
        pushExp(8'h20);
        pushExp(8'h21);
        startAt(8'h20, 3, 1'b1, 1'b0);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("ws_memReq", bus.memReq, 1);
                check("ws_memAddr", bus.memAddr, 8'h20 + 8'(b));
                check("ws_memAck", bus.memAck, (k == 3));
            end
        end
        runUntilDrained("ws_drain");

        // Redirect to 0x40 while the fetch of addr 5 is waiting
        for (int i = 0; i < 5; i++) pushExp(8'(i));
        startAt(8'h00, 2, 1'b1, 1'b0);
        waitReqAt(8'h05, "rd_found_req5");
        cyc();
        redirect = 1'b1;
        redirectPc = 8'h40;
        @(negedge clk);
        check("rd_memReq_c1", bus.memReq, 1);
        check("rd_memAddr_c1", bus.memAddr, 8'h05);
        check("rd_pre_bytes", expQ.size(), 0);
        pushExp(8'h40);
        pushExp(8'h41);
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        check("rd_memReq_c2", bus.memReq, 1);
        check("rd_memAddr_c2", bus.memAddr, 8'h05);
        check("rd_memAck_c2", bus.memAck, 1);
        check("rd_flushed", bus.instrValid, 0);
        @(negedge clk);
        check("rd_discarded", bus.instrValid, 0);
        check("rd_newReq", bus.memReq, 1);
        check("rd_newAddr", bus.memAddr, 8'h40);
        runUntilDrained("rd_drain");

        // Halt while BUSY: outstanding byte delivered, no new request until release
        pushExp(8'h60);
        startAt(8'h60, 3, 1'b1, 1'b0);
        waitReqAt(8'h60, "halt_found_req");
        cyc();
        halt = 1'b1;
        @(negedge clk);
        check("halt_busy_req", bus.memReq, 1);
        check("halt_busy_addr", bus.memAddr, 8'h60);
        @(negedge clk);
        @(negedge clk);
        check("halt_ack", bus.memAck, 1);
        reqSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.memReq) reqSeen++;
        end
        check("halt_no_req", reqSeen, 0);
        check("halt_delivered", expQ.size(), 0);
        cyc();
        halt = 1'b0;
        @(negedge clk);
        check("halt_resume_req", bus.memReq, 1);
        check("halt_resume_addr", bus.memAddr, 8'h61);

        // Reset in the middle of a BUSY request
        cyc();
        rst = 1'b0;
        bus.instrReady = 1'b0;
        cyc();
        @(negedge clk);
        check("mrst_memReq", bus.memReq, 0);
        check("mrst_valid", bus.instrValid, 0);
        check("mrst_memAddr", bus.memAddr, 8'h00);
        check("mrst_instr", bus.instr, 8'h00);
        check("mrst_instrPc", bus.instrPc, 8'h00);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("mrst_refetch_req", bus.memReq, 1);
        check("mrst_refetch_addr", bus.memAddr, 8'h00);
        cyc();
        halt = 1'b1;

        // Redirect table, including address wrap at 0xFF
        foreach (vectors[v]) begin
            addrQ.delete();
            for (int i = 0; i < vectors[v].nBytes; i++) begin
                addrQ.push_back(vectors[v].target + 8'(i));
                pushExp(vectors[v].target + 8'(i));
            end
            startAt(vectors[v].target, vectors[v].waits, 1'b1, 1'b1);
            runUntilDrained("tbl_drain");
            chkAddr = 1'b0;
            check("tbl_lastPc", lastPc, vectors[v].lastPc);
            check("tbl_lastInstr", lastInstr, vectors[v].lastInstr);
            check("tbl_addr_left", addrQ.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
